// File: rtl/la_pkg.sv
// Shared encodings for the logic analyzer capture path: FSM states, trigger modes
// and register offsets within a core's bus window.
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MOVE       = 3'd1,
    ST_IN_POS     = 3'd2,
    ST_CAPTURING  = 3'd3,
    ST_CAPTURED   = 3'd4
  } la_state_e;

  localparam logic [1:0] MODE_SINGLE    = 2'd0;
  localparam logic [1:0] MODE_INCR      = 2'd1;
  localparam logic [1:0] MODE_IMMEDIATE = 2'd2;

  localparam logic [2:0] REG_STATE     = 3'd0;
  localparam logic [2:0] REG_MODE      = 3'd1;
  localparam logic [2:0] REG_LOC       = 3'd2;
  localparam logic [2:0] REG_START     = 3'd3;
  localparam logic [2:0] REG_STOP      = 3'd4;
  localparam logic [2:0] REG_READ_PTR  = 3'd5;
  localparam logic [2:0] REG_WRITE_PTR = 3'd6;

endpackage

// File: rtl/la_capture_fsm.sv
// Capture controller: gates sample-memory writes around the trigger; bus stage has 1-cycle latency.
// No backpressure (bus always accepted); immediate mode present only with LA_CAPTURE_IMMEDIATE_EN.
module la_capture_fsm
  import la_pkg::*;
#(
  parameter int BASE_ADDR    = 0,
  parameter int SAMPLE_DEPTH = 4096,
  parameter int AW           = $clog2(SAMPLE_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trig,
  input  logic [15:0]   addr_i,
  input  logic [15:0]   data_i,
  input  logic          rw_i,
  input  logic          valid_i,
  output logic [15:0]   addr_o,
  output logic [15:0]   data_o,
  output logic          rw_o,
  output logic          valid_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o
);

  localparam int CW = AW + 1;

  la_state_e     state_q, state_d;
  logic [1:0]    mode_q;
  logic [AW-1:0] loc_q, rp_q, rp_d, wp_q, cur_addr;
  logic [CW-1:0] cnt_q, cnt_d, remain;
  logic [16:0]   off_full;
  logic [2:0]    off;
  logic          hit, wr_hit, rd_hit, start_req, stop_req;
  logic          ptr_clr, wr_dec, mode_ok;
  logic [15:0]   rd_val;

  // An address below the base wraps to a large offset and so misses the window.
  assign off_full  = {1'b0, addr_i} - 17'(BASE_ADDR);
  assign hit       = valid_i && (off_full <= 17'd6);
  assign off       = off_full[2:0];
  assign wr_hit    = hit && rw_i;
  assign rd_hit    = hit && !rw_i;
  assign start_req = wr_hit && (off == REG_START);
  assign stop_req  = wr_hit && (off == REG_STOP);

  // write_pointer advances when the registered write retires, so the address of
  // the write being decided this cycle is one ahead while we_o is high.
  assign cur_addr = wp_q + AW'(we_o);
  assign remain   = CW'(SAMPLE_DEPTH) - {1'b0, loc_q} - CW'(1);
  assign waddr_o  = wp_q;

`ifdef LA_CAPTURE_IMMEDIATE_EN
  assign mode_ok = (data_i <= 16'(MODE_IMMEDIATE));
`else
  assign mode_ok = (data_i <= 16'(MODE_INCR));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_o  <= '0;
      data_o  <= '0;
      rw_o    <= 1'b0;
      valid_o <= 1'b0;
      we_o    <= 1'b0;
      state_q <= ST_IDLE;
      mode_q  <= MODE_SINGLE;
      loc_q   <= '0;
      rp_q    <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      addr_o  <= addr_i;
      rw_o    <= rw_i;
      valid_o <= valid_i;
      data_o  <= rd_hit ? rd_val : data_i;
      we_o    <= wr_dec;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rp_q    <= ptr_clr ? '0 : rp_d;
      wp_q    <= ptr_clr ? '0 : wp_q + AW'(we_o);
      if (wr_hit && state_q == ST_IDLE) begin
        if (off == REG_MODE && mode_ok) mode_q <= data_i[1:0];
        if (off == REG_LOC) begin
          if (32'(data_i) > SAMPLE_DEPTH - 1) loc_q <= AW'(SAMPLE_DEPTH - 1);
          else                                loc_q <= data_i[AW-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rp_d    = rp_q;
    ptr_clr = 1'b0;
    if (stop_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_req) begin
          ptr_clr = 1'b1;
          cnt_d   = '0;
          if (mode_q == MODE_SINGLE) begin
            state_d = (loc_q != '0) ? ST_MOVE : ST_IN_POS;
          end else begin
            state_d = ST_CAPTURING;
            cnt_d   = CW'(SAMPLE_DEPTH);
          end
        end
        ST_MOVE: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == {1'b0, loc_q}) begin
            state_d = ST_IN_POS;
            cnt_d   = '0;
          end
        end
        ST_IN_POS: begin
          rp_d = cur_addr - loc_q;
          if (trig) begin
            cnt_d   = remain;
            state_d = (remain == '0) ? ST_CAPTURED : ST_CAPTURING;
          end
        end
        ST_CAPTURING: if (wr_dec) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_CAPTURED;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_dec = 1'b0;
    rd_val = '0;
    case (state_q)
      ST_MOVE, ST_IN_POS: wr_dec = 1'b1;
      ST_CAPTURING:       wr_dec = (mode_q == MODE_INCR) ? trig : 1'b1;
      default:            wr_dec = 1'b0;
    endcase
    if (stop_req) wr_dec = 1'b0;
    case (off)
      REG_STATE:     rd_val = 16'(state_q);
      REG_MODE:      rd_val = 16'(mode_q);
      REG_LOC:       rd_val = 16'(loc_q);
      REG_READ_PTR:  rd_val = 16'(rp_q);
      REG_WRITE_PTR: rd_val = 16'(wp_q);
      default:       rd_val = '0;
    endcase
  end

endmodule

// File: tb/tb_la_capture_fsm.sv
// Directed bench for la_capture_fsm: per-cycle bus pass-through checks plus a write-stream scoreboard.
module tb_la_capture_fsm;

  localparam int D    = 16;
  localparam int BASE = 16'h0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] addr_i = '0, data_i = '0;
  logic        rw_i = 1'b0, valid_i = 1'b0;
  logic [15:0] addr_o, data_o;
  logic        rw_o, valid_o, we_o;
  logic [3:0]  waddr_o;

  la_capture_fsm #(.BASE_ADDR(BASE), .SAMPLE_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig),
    .addr_i(addr_i), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o), .valid_o(valid_o),
    .we_o(we_o), .waddr_o(waddr_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wq_cyc[$], wq_addr[$];
  int ec[$], ea[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bus-stage model: every output is last cycle's input, except data on an in-window read.
  logic [15:0] e_addr, e_data;
  logic        e_rw, e_vld, e_rdhit;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_addr <= '0; e_data <= '0; e_rw <= 1'b0; e_vld <= 1'b0; e_rdhit <= 1'b0;
    end else begin
      e_addr  <= addr_i;
      e_data  <= data_i;
      e_rw    <= rw_i;
      e_vld   <= valid_i;
      e_rdhit <= valid_i && !rw_i && (int'(addr_i) >= BASE) && (int'(addr_i) <= BASE + 6);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("addr_o", addr_o, e_addr);
      check("rw_o", rw_o, e_rw);
      check("valid_o", valid_o, e_vld);
      if (!e_rdhit) check("data_o", data_o, e_data);
      if (we_o) begin
        wq_cyc.push_back(cyc);
        wq_addr.push_back(int'(waddr_o));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input int d);
    addr_i = 16'(BASE + off); data_i = 16'(d); rw_i = 1'b1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0; rw_i = 1'b0; data_i = '0;
  endtask

  task automatic rd(input int off, output int d);
    addr_i = 16'(BASE + off); data_i = 16'hA5A5; rw_i = 1'b0; valid_i = 1'b1;
    tick();
    d = int'(data_o);
    valid_i = 1'b0; data_i = '0;
  endtask

  task automatic rd_check(input string name, input int off, input int exp);
    int d;
    rd(off, d);
    check(name, d, exp);
  endtask

  task automatic clear_log();
    wq_cyc = {}; wq_addr = {}; ec = {}; ea = {};
  endtask

  // n back-to-back writes starting at address 0, first visible in cycle first_cyc.
  task automatic expect_run(input int first_cyc, input int n);
    for (int k = 0; k < n; k++) begin
      ec.push_back(first_cyc + k);
      ea.push_back(k % D);
    end
  endtask

  task automatic compare_log(input string name);
    int bad;
    check({name, "_count"}, wq_cyc.size(), ec.size());
    bad = -1;
    for (int i = 0; i < ec.size() && i < wq_cyc.size(); i++)
      if (bad < 0 && (wq_cyc[i] != ec[i] || wq_addr[i] != ea[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_seq: write %0d got cycle %0d addr %0d, expected cycle %0d addr %0d",
               name, bad, wq_cyc[bad], wq_addr[bad], ec[bad], ea[bad]);
    end
  endtask

  initial begin
    int n0, cnt;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_we_o", we_o, 0);
    check("rst_waddr_o", waddr_o, 0);
    check("rst_addr_o", addr_o, 0);
    check("rst_data_o", data_o, 0);
    check("rst_rw_o", rw_o, 0);
    check("rst_valid_o", valid_o, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i <= 6; i++) rd_check($sformatf("rst_reg%0d", i), i, 0);
    addr_i = 16'(BASE + 7); data_i = 16'hBEEF; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("outside_rd_pass", data_o, 16'hBEEF);
    addr_i = 16'(BASE - 15); data_i = 16'd1; rw_i = 1'b1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0; rw_i = 1'b0;
    rd_check("outside_wr_ignored", 1, 0);

    // Single-shot, L=4, trigger after 10 in-position cycles
    wr(1, 0);
    wr(2, 4);
    rd_check("loc_4", 2, 4);
    clear_log();
    wr(3, 0);
    n0 = cyc;
    expect_run(n0 + 1, 4 + 10 + (D - 4));
    repeat (14) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (20) tick();
    compare_log("single");
    rd_check("single_state", 0, 4);
    rd_check("single_rp", 5, 10);
    rd_check("single_wp", 6, 10);

    // Incremental, trig on 3 of every 5 cycles
    wr(4, 0);
    wr(1, 1);
    clear_log();
    wr(3, 0);
    n0 = cyc;
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      trig = ((j % 5) < 3);
      if (trig && cnt < D) begin
        ec.push_back(n0 + 1 + j);
        ea.push_back(cnt);
        cnt++;
      end
      tick();
    end
    trig = 1'b0;
    tick();
    compare_log("incr");
    rd_check("incr_state", 0, 4);
    rd_check("incr_wp", 6, 0);

    // trigger_loc saturation, trigger in first in-position cycle
    wr(4, 0);
    wr(1, 0);
    wr(2, 20);
    rd_check("loc_sat", 2, 15);
    clear_log();
    wr(3, 0);
    n0 = cyc;
    expect_run(n0 + 1, D);
    repeat (15) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    rd_check("sat_state_next", 0, 4);
    repeat (3) tick();
    compare_log("sat");
    rd_check("sat_rp", 5, 0);
    rd_check("sat_wp", 6, 0);

    // Stop during capture; mode write while capturing is ignored
    wr(4, 0);
    wr(1, 1);
    clear_log();
    wr(3, 0);
    n0 = cyc;
    trig = 1'b1;
    repeat (5) tick();
    wr(1, 0);
    wr(4, 0);
    check("stop_we_o", we_o, 0);
    trig = 1'b0;
    expect_run(n0 + 1, 6);
    repeat (3) tick();
    compare_log("stop");
    rd_check("stop_state", 0, 0);
    rd_check("stop_mode_kept", 1, 1);
    rd_check("stop_wp", 6, 6);

    // Immediate mode and illegal mode values
    wr(1, 2);
`ifdef LA_CAPTURE_IMMEDIATE_EN
    rd_check("mode2", 1, 2);
`else
    rd_check("mode2", 1, 1);
`endif
    wr(1, 3);
`ifdef LA_CAPTURE_IMMEDIATE_EN
    rd_check("mode3", 1, 2);
`else
    rd_check("mode3", 1, 1);
`endif
    clear_log();
    wr(3, 0);
    n0 = cyc;
`ifdef LA_CAPTURE_IMMEDIATE_EN
    expect_run(n0 + 1, D);
`endif
    repeat (20) tick();
    compare_log("imm");
`ifdef LA_CAPTURE_IMMEDIATE_EN
    rd_check("imm_state", 0, 4);
`else
    rd_check("imm_state", 0, 3);
`endif
    rd_check("imm_wp", 6, 0);
    wr(4, 0);

    // Reset mid-capture
    wr(1, 0);
    wr(2, 4);
    wr(3, 0);
    repeat (3) tick();
    check("pre_rst_we_o", we_o, 1);
    clear_log();
    rst_n = 1'b0;
    #1;
    check("mid_rst_we_o", we_o, 0);
    check("mid_rst_waddr_o", waddr_o, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    compare_log("after_rst");
    rd_check("after_rst_state", 0, 0);
    rd_check("after_rst_loc", 2, 0);
    rd_check("after_rst_wp", 6, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/la_capture_fsm.md
# la_capture_fsm

Capture controller for the logic analyzer core. Sits directly downstream of the trigger block: it consumes the block's `trig` output, decides which cycles are written into the sample memory, and reports capture progress. Like every core, it is a register-bus stage: it passes bus transactions through with one cycle of latency and answers reads and writes that fall inside its own address window.

## Interface
Parameters:
- `BASE_ADDR`, default 0: first bus address of this block.
- `SAMPLE_DEPTH`, default 4096: number of sample memory entries. Must be a power of two, between 2 and 65536.
- `AW`, default `$clog2(SAMPLE_DEPTH)`: sample memory address width.

Ports:
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trig`  in  1  combinational trigger from the trigger block, sampled on `clk`.
- `addr_i`  in  16  bus address.
- `data_i`  in  16  bus write data.
- `rw_i`  in  1  bus direction: 1 = write, 0 = read.
- `valid_i`  in  1  bus transaction valid.
- `addr_o`  out  16  registered pass-through of `addr_i`.
- `data_o`  out  16  pass-through of `data_i`, or read data when this block hits.
- `rw_o`  out  1  registered pass-through of `rw_i`.
- `valid_o`  out  1  registered pass-through of `valid_i`.
- `we_o`  out  1  sample memory write enable.
- `waddr_o`  out  AW  sample memory write address; equals `write_pointer`.

## Operation
Register map, offset from `BASE_ADDR`:
- 0: `state`. Read-only.
- 1: `trigger_mode`. Read/write. 0 = single-shot, 1 = incremental, 2 = immediate.
- 2: `trigger_loc`. Read/write. Writes saturate to `SAMPLE_DEPTH-1`.
- 3: `request_start`. Write-only strobe; the data value is ignored.
- 4: `request_stop`. Write-only strobe; the data value is ignored.
- 5: `read_pointer`. Read-only.
- 6: `write_pointer`. Read-only.
- Reads of write-only addresses return 0.

Bus rules:
- Reads and writes to offsets 0–6 act only when the address is inside the window.
- Writes to `trigger_mode` and `trigger_loc` are ignored unless the block is in IDLE.
- Any write to a read-only offset is ignored.

States: IDLE=0, MOVE_TO_POSITION=1, IN_POSITION=2, CAPTURING=3, CAPTURED=4.

`request_start` is honoured only in IDLE. It clears both pointers and the internal counter, then enters a state chosen by mode:
- Single-shot with `trigger_loc`=L>0: MOVE_TO_POSITION.
- Single-shot with L=0: IN_POSITION.
- Incremental or immediate: CAPTURING.

State behaviour:
- MOVE_TO_POSITION:
  - Assert `we_o` every cycle; `write_pointer`++ every cycle.
  - After L writes, go to IN_POSITION.
  - `trig` is ignored.
- IN_POSITION:
  - Assert `we_o` every cycle; `write_pointer`++ with wrap at `SAMPLE_DEPTH`.
  - `read_pointer` = (`write_pointer` − L) mod `SAMPLE_DEPTH`, tracked every cycle.
  - When `trig`=1, that cycle's sample is written, `read_pointer` freezes, and the state goes to CAPTURING with D−L−1 samples remaining.
  - If D−L−1 is 0, go straight to CAPTURED instead.
- CAPTURING, single-shot and immediate:
  - Write every cycle until the remaining count reaches 0, then go to CAPTURED.
  - Immediate mode ignores `trig` and writes exactly `SAMPLE_DEPTH` samples.
- CAPTURING, incremental:
  - `we_o` = `trig`; a pointer advance happens only when `trig`=1.
  - CAPTURED after `SAMPLE_DEPTH` writes.
- CAPTURED: hold; `we_o`=0.

`request_stop`, from any state: go to IDLE with `we_o`=0. Pointers are left unchanged so that the host can still read them.

## Timing
- Reset values:
  - `addr_o`, `data_o`, `rw_o`, `valid_o`, `we_o`, `waddr_o`: all 0.
  - State IDLE; mode 0; `trigger_loc` 0; both pointers 0.
- Bus pass-through latency is 1 cycle. Read data appears on `data_o` in the same cycle as `valid_o`.
- Register write at edge N:
  - The state changes at edge N.
  - The first `we_o`=1 occurs in cycle N+1.
- `we_o` and `waddr_o` are registered. The sample memory latches its probe pipeline, which is aligned by one register, at the same edge.
- `trig` is acted on in the cycle it is high. No extra latency between the trigger sample and its write.
- Asserting `rst_n` mid-capture aborts immediately to the reset values; no write is in flight afterwards.

## Configuration
- `LA_CAPTURE_IMMEDIATE_EN` defined:
  - Immediate mode (2) is supported.
- Not defined:
  - Writing 2 to `trigger_mode` is ignored; the register keeps its previous value.
  - Immediate-mode logic is absent.
- Modes 0 and 1 are always present. A mode value of 3 is always ignored.

## Structure
- Shared package `la_pkg` holds:
  - the state enum with fixed encodings 0–4;
  - the mode encodings;
  - the register offsets 0–6.
- No sub-module. The register decode, state machine and pointer logic are one always block plus combinational next-state logic.

## Test plan
- Reset, then read offsets 0–6 → all read 0; bus outputs lag their inputs by 1 cycle.
- D=16, single-shot, L=4, `trig` pulses 10 cycles after MOVE_TO_POSITION ends:
  - 4 MOVE writes, 10 IN_POSITION writes, then the trigger write plus 11 more;
  - CAPTURED with `read_pointer`=(14−4) mod 16=10.
- D=16, incremental, `trig` high on 3 cycles out of every 5 → exactly 16 writes, then CAPTURED; `write_pointer`=0 after wrap.
- Write `trigger_loc`=20 with D=16 → reads back 15. `trig` in the first IN_POSITION cycle → CAPTURED the next cycle.
- `request_stop` during CAPTURING → IDLE, `we_o`=0 the next cycle. A `trigger_mode` write while in CAPTURING is ignored.
- With the macro undefined, write mode 2 → reads back the prior value. With it defined, start → 16 consecutive writes, then CAPTURED.
